// File: rtl/checksum_pkg.sv
// Shared types and helpers for the streaming ones'-complement checksum receiver.
package checksum_pkg;

    localparam int CSUM_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FOLD,
        REPORT
    } csum_state_t;

    // Two end-around-carry folds are always enough to bring a 32-bit sum into 16 bits.
    function automatic logic [CSUM_W-1:0] csum_fold(input logic [31:0] acc);
        logic [16:0] s1;
        logic [16:0] s2;
        s1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
        s2 = {1'b0, s1[15:0]} + {16'b0, s1[16]};
        return s2[15:0];
    endfunction

endpackage

// File: rtl/csum_beat_adder.sv
// Combinational partial sum of the enabled 16-bit words in one beat.
module csum_beat_adder
    import checksum_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic [CSUM_W*WORDS-1:0] data,
    input  logic [WORDS-1:0]        keep,
    output logic [19:0]             psum
);

    logic [CSUM_W-1:0] word_masked [WORDS];

    // Word 0 sits in the most significant lane; keep bit i gates word i.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_mask
        assign word_masked[gi] = keep[gi] ? data[CSUM_W*(WORDS-gi)-1 -: CSUM_W] : '0;
    end

    always_comb begin
        psum = '0;
        for (int i = 0; i < WORDS; i++) begin
            psum = psum + {4'b0, word_masked[i]};
        end
    end

endmodule

// File: rtl/checksum_stream_rx.sv
// Packet-level ones'-complement checksum checker: accumulate beats, fold, report.
module checksum_stream_rx
    import checksum_pkg::*;
#(
    parameter int WORDS     = 2,
    parameter int MAX_BEATS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CSUM_W*WORDS-1:0] in_data,
    input  logic [WORDS-1:0]        in_keep,
    input  logic                    in_last,
    input  logic [CSUM_W-1:0]       in_checksum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_ok,
    output logic [CSUM_W-1:0]       out_sum,
    output logic                    out_len_err
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

    if (WORDS < 1 || WORDS > 8) begin : g_bad_words
        $error("checksum_stream_rx: WORDS must be in 1..8");
    end
    if (MAX_BEATS < 1 || WORDS * MAX_BEATS > 65536) begin : g_bad_beats
        $error("checksum_stream_rx: MAX_BEATS out of range");
    end

    csum_state_t       state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              len_err_q, len_err_d;
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic [CSUM_W-1:0] sum_q, sum_d;
    logic              ok_q, ok_d;
    logic              res_len_err_q, res_len_err_d;

    logic [19:0]       psum;
    logic [CSUM_W-1:0] folded;
    logic [16:0]       verify_raw;
    logic [CSUM_W-1:0] verify;
    logic              beat_fire;

    csum_beat_adder #(.WORDS(WORDS)) u_adder (
        .data (in_data),
        .keep (in_keep),
        .psum (psum)
    );

    // Ready decodes straight from the state register, so it never depends on out_ready.
    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == REPORT);
    assign beat_fire = in_valid && in_ready;

    assign folded     = csum_fold(acc_q);
    assign verify_raw = {1'b0, folded} + {1'b0, csum_q};
    assign verify     = csum_fold({15'b0, verify_raw});

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        len_err_d     = len_err_q;
        csum_d        = csum_q;
        sum_d         = sum_q;
        ok_d          = ok_q;
        res_len_err_d = res_len_err_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (beat_fire) begin
                    acc_d = acc_q + {12'b0, psum};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (!in_last) begin
                        len_err_d = 1'b1;
                    end
                    if (in_last) begin
                        csum_d  = in_checksum;
                        state_d = FOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            FOLD: begin
                sum_d         = ~folded;
                ok_d          = (verify == 16'hFFFF) && !len_err_q;
                res_len_err_d = len_err_q;
                state_d       = REPORT;
            end
            REPORT: begin
                if (out_ready) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    len_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            len_err_q     <= 1'b0;
            csum_q        <= '0;
            sum_q         <= '0;
            ok_q          <= 1'b0;
            res_len_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            len_err_q     <= len_err_d;
            csum_q        <= csum_d;
            sum_q         <= sum_d;
            ok_q          <= ok_d;
            res_len_err_q <= res_len_err_d;
        end
    end

    assign out_ok      = ok_q;
    assign out_sum     = sum_q;
    assign out_len_err = res_len_err_q;

endmodule
